// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared state encoding, mode constants and trellis step helpers
package viterbi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACE = 2'd1,
    ST_HOLD  = 2'd2
  } trace_state_t;

  localparam logic MODE_SLIDE = 1'b0;
  localparam logic MODE_FLUSH = 1'b1;

  // Bit that drove the encoder into state s: the newest bit sits in the MSB.
  function automatic logic decoded_bit(input int m, input logic [31:0] s);
    return s[m-1];
  endfunction

  // Previous state: drop the newest bit, re-append the bit shifted out (the decision).
  function automatic logic [31:0] predecessor(input int m, input logic [31:0] s, input logic d);
    logic [31:0] mask;
    mask = (32'd1 << m) - 32'd1;
    if (m == 1) begin
      return {31'd0, d};
    end
    return ((s << 1) | {31'd0, d}) & mask;
  endfunction

endpackage

// File: rtl/survivor_mem.sv
// rtl/survivor_mem.sv - survivor decision storage, sync write, async read
module survivor_mem #(
  parameter int AW = 6,
  parameter int W  = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  // Write lands on the edge, so a same-cycle read still sees the old column.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// rtl/viterbi_traceback.sv - survivor-path traceback with sliding and flush modes
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int M        = 2,
  parameter int TB_DEPTH = 16,
  parameter int OUT_BITS = 8,
  parameter int AW       = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_dec_valid,
  input  logic [(1<<M)-1:0]   i_dec,
  input  logic                i_tb_start,
  input  logic                i_mode,
  input  logic [M-1:0]        i_start_state,
  input  logic                i_out_ready,
  output logic [OUT_BITS-1:0] o_data,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_err
);

  localparam int NS        = 1 << M;
  localparam int MEM_DEPTH = 1 << AW;
  localparam int L_SLIDE   = TB_DEPTH + OUT_BITS;
  localparam int CW        = $clog2(L_SLIDE + 1);

  localparam logic [AW:0]   FILL_MAX   = (AW+1)'(MEM_DEPTH);
  localparam logic [AW:0]   NEED_SLIDE = (AW+1)'(L_SLIDE);
  localparam logic [AW:0]   NEED_FLUSH = (AW+1)'(OUT_BITS);
  localparam logic [CW-1:0] LEN_SLIDE  = CW'(L_SLIDE);
  localparam logic [CW-1:0] LEN_FLUSH  = CW'(OUT_BITS);
  localparam logic [CW-1:0] SKIP_SLIDE = CW'(TB_DEPTH);

  logic [AW-1:0]       wr_ptr;
  logic [AW:0]         fill;
  trace_state_t        state;
  logic [AW-1:0]       rd_ptr;
  logic [M-1:0]        cur;
  logic [CW-1:0]       len;
  logic [CW-1:0]       skip;
  logic [CW-1:0]       cnt;
  logic [OUT_BITS-1:0] word;
  logic [NS-1:0]       rd_col;
  logic                dec_bit;
  logic                step_bit;
  logic [M-1:0]        prev_state;
  logic [AW:0]         need;

  survivor_mem #(
    .AW(AW),
    .W (NS)
  ) u_mem (
    .clk  (clk),
    .we   (i_dec_valid),
    .waddr(wr_ptr),
    .wdata(i_dec),
    .raddr(rd_ptr),
    .rdata(rd_col)
  );

  assign dec_bit    = rd_col[cur];
  assign step_bit   = decoded_bit(M, 32'(cur));
  assign prev_state = M'(predecessor(M, 32'(cur), dec_bit));
  assign need       = (i_mode == MODE_FLUSH) ? NEED_FLUSH : NEED_SLIDE;

  // Decision columns are stored every valid cycle regardless of traceback activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (i_dec_valid) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (fill != FILL_MAX) begin
        fill <= fill + (AW+1)'(1);
      end
    end
  end

  // Traceback controller: one trellis step per TRACE cycle, word held in HOLD until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rd_ptr  <= '0;
      cur     <= '0;
      len     <= '0;
      skip    <= '0;
      cnt     <= '0;
      word    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_tb_start) begin
            if (fill >= need) begin
              state  <= ST_TRACE;
              o_busy <= 1'b1;
              cur    <= i_start_state;
              rd_ptr <= wr_ptr - AW'(1);
              cnt    <= '0;
              word   <= '0;
              len    <= (i_mode == MODE_FLUSH) ? LEN_FLUSH : LEN_SLIDE;
              skip   <= (i_mode == MODE_FLUSH) ? '0 : SKIP_SLIDE;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        ST_TRACE: begin
          if (cnt == len) begin
            state   <= ST_HOLD;
            o_data  <= word;
            o_valid <= 1'b1;
          end else begin
            // Newest kept bit is shifted toward the MSB so the oldest ends in bit 0.
            if (cnt >= skip) begin
              word <= (word << 1) | OUT_BITS'(step_bit);
            end
            cur    <= prev_state;
            rd_ptr <= rd_ptr - AW'(1);
            cnt    <= cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (i_out_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb/tb_viterbi_traceback.sv - directed checks of traceback decode, timing, errors and reset
module tb_viterbi_traceback;

  localparam int M  = 2;
  localparam int NS = 4;
  localparam int OB = 8;

  typedef struct {
    logic       mode;
    int         prefix;
    logic [7:0] msg;
    int         tail;
    logic       zero_cols;
    logic       wr_busy;
    logic [7:0] exp_data;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_dec_valid = 1'b0;
  logic [NS-1:0] i_dec = '0;
  logic          i_tb_start = 1'b0;
  logic          i_mode = 1'b0;
  logic [M-1:0]  i_start_state = '0;
  logic          i_out_ready = 1'b0;
  logic [OB-1:0] o_data;
  logic          o_valid;
  logic          o_busy;
  logic          o_err;

  int            total = 0;
  int            bad = 0;
  logic [M-1:0]  enc_state = '0;
  vec_t          vecs [6];

  viterbi_traceback dut (
    .clk          (clk),
    .rst          (rst),
    .i_dec_valid  (i_dec_valid),
    .i_dec        (i_dec),
    .i_tb_start   (i_tb_start),
    .i_mode       (i_mode),
    .i_start_state(i_start_state),
    .i_out_ready  (i_out_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Golden rate-1 shift-register trellis: new bit enters the MSB, LSB is shifted out.
  task automatic enc_push(input logic u, input logic zero_cols);
    logic [M-1:0]  nxt;
    logic [NS-1:0] col;
    nxt = {u, enc_state[M-1:1]};
    col = zero_cols ? '0 : NS'($urandom);
    col[nxt] = enc_state[0];
    i_dec_valid = 1'b1;
    i_dec = col;
    tick;
    i_dec_valid = 1'b0;
    i_dec = '0;
    enc_state = nxt;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic zero_cols);
    for (int i = 0; i < 8; i++) enc_push(b[i], zero_cols);
  endtask

  task automatic push_zeros(input int n, input logic zero_cols);
    for (int i = 0; i < n; i++) enc_push(1'b0, zero_cols);
  endtask

  task automatic start(input logic mode, input logic [M-1:0] ss);
    i_tb_start = 1'b1;
    i_mode = mode;
    i_start_state = ss;
    tick;
    i_tb_start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat, input logic wr);
    int   cyc;
    logic err_seen;
    cyc = 0;
    err_seen = 1'b0;
    while (!o_valid && cyc < 200) begin
      if (wr) enc_push(1'($urandom), 1'b0);
      else tick;
      cyc++;
      if (o_err) err_seen = 1'b1;
    end
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_err"}, 32'(err_seen), 32'd0);
  endtask

  task automatic accept(input string name);
    i_out_ready = 1'b1;
    tick;
    i_out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(o_valid), 32'd0);
    check({name, "_busy_drop"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [23:0] seq;
    logic        valid_seen;

    vecs[0] = '{1'b0, 0,  8'h00, 16, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 0,  8'hA5, 16, 1'b0, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 92, 8'h3C, 0,  1'b0, 1'b0, 8'h3C};
    vecs[3] = '{1'b0, 5,  8'h81, 16, 1'b0, 1'b1, 8'h81};
    vecs[4] = '{1'b1, 40, 8'hFF, 0,  1'b0, 1'b1, 8'hFF};
    vecs[5] = '{1'b0, 3,  8'h5A, 16, 1'b0, 1'b1, 8'h5A};

    repeat (2) tick;
    check("reset_data", 32'(o_data), 32'd0);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    rst = 1'b1;
    tick;

    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      for (int p = 0; p < vecs[v].prefix; p++) enc_push(1'($urandom), 1'b0);
      push_byte(vecs[v].msg, vecs[v].zero_cols);
      push_zeros(vecs[v].tail, vecs[v].zero_cols);
      start(vecs[v].mode, enc_state);
      check({nm, "_start_busy"}, 32'(o_busy), 32'd1);
      check({nm, "_start_err"}, 32'(o_err), 32'd0);
      check({nm, "_start_valid"}, 32'(o_valid), 32'd0);
      wait_valid(nm, vecs[v].mode ? 9 : 25, vecs[v].wr_busy);
      check({nm, "_data"}, 32'(o_data), 32'(vecs[v].exp_data));
      accept(nm);
    end

    push_byte(8'hE7, 1'b0);
    push_zeros(16, 1'b0);
    start(1'b0, enc_state);
    wait_valid("hold", 25, 1'b0);
    for (int c = 0; c < 5; c++) begin
      i_tb_start = (c == 2);
      i_mode = 1'b1;
      i_start_state = 2'd3;
      tick;
      i_tb_start = 1'b0;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_data", 32'(o_data), 32'hE7);
      check("hold_err", 32'(o_err), 32'd0);
      check("hold_busy", 32'(o_busy), 32'd1);
    end
    i_mode = 1'b0;
    accept("hold");

    rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    enc_state = '0;
    seq = {16'h0000, 8'hC3};
    for (int i = 0; i < 10; i++) enc_push(seq[i], 1'b0);
    start(1'b0, enc_state);
    check("short_err_pulse", 32'(o_err), 32'd1);
    check("short_busy", 32'(o_busy), 32'd0);
    tick;
    check("short_err_clear", 32'(o_err), 32'd0);
    valid_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (o_valid || o_busy) valid_seen = 1'b1;
    end
    check("short_no_valid", 32'(valid_seen), 32'd0);
    for (int i = 10; i < 23; i++) enc_push(seq[i], 1'b0);
    start(1'b0, enc_state);
    check("fill23_err", 32'(o_err), 32'd1);
    enc_push(seq[23], 1'b0);
    start(1'b0, enc_state);
    check("fill24_err", 32'(o_err), 32'd0);
    check("fill24_busy", 32'(o_busy), 32'd1);
    wait_valid("fill24", 25, 1'b0);
    check("fill24_data", 32'(o_data), 32'hC3);
    accept("fill24");

    push_byte(8'h3A, 1'b0);
    push_zeros(16, 1'b0);
    start(1'b0, enc_state);
    repeat (10) tick;
    check("midreset_busy_before", 32'(o_busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_data", 32'(o_data), 32'd0);
    check("midreset_valid", 32'(o_valid), 32'd0);
    check("midreset_busy", 32'(o_busy), 32'd0);
    check("midreset_err", 32'(o_err), 32'd0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    check("postreset_valid", 32'(o_valid), 32'd0);
    check("postreset_busy", 32'(o_busy), 32'd0);
    push_byte(8'h96, 1'b0);
    push_zeros(16, 1'b0);
    start(1'b0, enc_state);
    check("postreset_start_err", 32'(o_err), 32'd0);
    wait_valid("postreset", 25, 1'b0);
    check("postreset_data", 32'(o_data), 32'h96);
    accept("postreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_traceback.md
VITERBI_TRACEBACK -- requirements
Module: viterbi_traceback

Interface
REQ-001 Parameter M, default 2, encoder state bits; trellis has 2^M states.
REQ-002 Parameter TB_DEPTH, default 16, merge-depth traceback steps discarded before output in sliding mode.
REQ-003 Parameter OUT_BITS, default 8, decoded bits per output word.
REQ-004 Parameter AW, default 6, survivor memory address width; MEM_DEPTH = 2^AW >= 2*(TB_DEPTH+OUT_BITS).
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 i_dec_valid  in  1  a decision column is present this cycle.
REQ-008 i_dec  in  2^M  decision vector; bit s = survivor select bit d for state s.
REQ-009 i_tb_start  in  1  request one traceback.
REQ-010 i_mode  in  1  0 = sliding (discard TB_DEPTH), 1 = flush (no discard); sampled with i_tb_start.
REQ-011 i_start_state  in  M  traceback start state; sampled with i_tb_start.
REQ-012 i_out_ready  in  1  consumer accepts o_data.
REQ-013 o_data  out  OUT_BITS  decoded word; bit 0 = oldest bit in time.
REQ-014 o_valid  out  1  o_data valid; held until accepted.
REQ-015 o_busy  out  1  traceback in progress or output pending.
REQ-016 o_err  out  1  one-cycle pulse: start rejected for insufficient history.

Function
REQ-017 Each cycle with i_dec_valid=1 the column SHALL be written at the write pointer, pointer incremented modulo MEM_DEPTH; fill count saturates at MEM_DEPTH.
REQ-018 Decision writes SHALL continue in every FSM state, including during traceback.
REQ-019 FSM states SHALL be IDLE, TRACE, HOLD.
REQ-020 In IDLE, i_tb_start=1 with fill >= L SHALL latch start state, mode and read pointer = last written column, and enter TRACE; L = TB_DEPTH+OUT_BITS (mode 0) or OUT_BITS (mode 1).
REQ-021 In IDLE, i_tb_start=1 with fill < L SHALL pulse o_err for one cycle and remain in IDLE.
REQ-022 i_tb_start in TRACE or HOLD SHALL be ignored without o_err.
REQ-023 Each TRACE cycle SHALL perform one step: decoded bit = s[M-1]; predecessor = {s[M-2:0], dec[s]}; read pointer decremented modulo MEM_DEPTH.
REQ-024 A column written at the same address as the read pointer in the same cycle SHALL NOT affect the current step (read uses snapshot-relative addressing; depth constraint prevents overwrite).
REQ-025 The first TB_DEPTH steps in mode 0 SHALL discard their bits; the next OUT_BITS bits SHALL fill o_data from bit OUT_BITS-1 down to bit 0.
REQ-026 After step L, FSM SHALL enter HOLD with o_valid=1; start accepted at edge T gives o_valid high from edge T+L+1.
REQ-027 In HOLD, o_data and o_valid SHALL stay constant until i_out_ready=1; on that edge o_valid drops, FSM returns to IDLE.
REQ-028 o_busy SHALL be 1 exactly in TRACE and HOLD.
REQ-029 For M=1 the predecessor SHALL be dec[s] alone.

Reset
REQ-030 rst=0 SHALL immediately force o_data=0, o_valid=0, o_busy=0, o_err=0, FSM=IDLE, write pointer=0, fill=0.
REQ-031 Reset mid-TRACE or mid-HOLD SHALL abandon the traceback with no output; survivor memory contents need not be cleared.

Structure
REQ-032 Package viterbi_pkg SHALL hold the FSM state encoding, mode constants (MODE_SLIDE, MODE_FLUSH) and the predecessor/decoded-bit functions.
REQ-033 Survivor storage SHALL be sub-module survivor_mem: 2^AW x 2^M, one synchronous write port, one asynchronous read port.

Verification
REQ-034 Defaults; 24 columns all zero, start state 0, mode 0 -> o_err=0, o_valid at T+25, o_data=8'h00.
REQ-035 Golden-encoder columns for message 8'hA5 then 16 zero bits, start state 0, mode 0 -> o_data=8'hA5.
REQ-036 Only 10 columns written, i_tb_start -> o_err pulse one cycle, o_busy=0, no o_valid.
REQ-037 i_out_ready low 5 cycles in HOLD, extra i_tb_start pulse -> o_data stable, o_valid held, start ignored, o_err=0.
REQ-038 100 continuous columns (pointer wraps), message 8'h3C in final 8 columns, mode 1, matching start state -> o_data=8'h3C.
REQ-039 rst=0 asserted at step 10 of TRACE -> all outputs 0 same cycle; after release, 24 new columns and start give correct word.
